// File: rtl/codeword_pkg.sv
// Shared types and constants for the codeword receiver: FSM states, codeword
// geometry and the wire-order to payload mapping.
package codeword_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } state_e;

  localparam int CW_W       = 6;
  localparam int PL_W       = 5;
  localparam int C1_IDX     = 0;
  localparam int C2_IDX     = 1;
  localparam int C3_IDX     = 2;
  localparam int C4_IDX     = 3;
  localparam int PARITY_IDX = 4;
  localparam int C6_IDX     = 5;

  // Payload is packed {c6,c4,c3,c2,c1}; the parity bit is dropped.
  function automatic logic [PL_W-1:0] extract_payload(input logic [CW_W-1:0] cw);
    return {cw[C6_IDX], cw[C4_IDX], cw[C3_IDX], cw[C2_IDX], cw[C1_IDX]};
  endfunction

endpackage

// File: rtl/codeword_rx_shift6.sv
// 6-bit serial-in shift register with load enable, synchronous clear and a
// bit counter; full flags the load that completes the codeword.
module cw_shift6
  import codeword_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            load,
  input  logic            bit_in,
  output logic [CW_W-1:0] data,
  output logic            full
);

  logic [CW_W-1:0] sreg_q, sreg_d;
  logic [2:0]      cnt_q, cnt_d;

  // First bit on the wire ends up at index 0 after six shifts.
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    full   = load && (cnt_q == 3'(CW_W - 1));
    if (clr) begin
      sreg_d = '0;
      cnt_d  = '0;
    end else if (load) begin
      sreg_d = {bit_in, sreg_q[CW_W-1:1]};
      cnt_d  = full ? '0 : cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data = sreg_q;

endmodule

// File: rtl/codeword_rx.sv
// Serial codeword receiver: deserialise, parity-check and hold the last good
// payload. Optional saturating parity-error counter under CODEWORD_ERRCNT_EN.
module codeword_rx
  import codeword_pkg::*;
#(
  parameter int PARITY_ODD  = 0,
  parameter int TIMEOUT_CYC = 16
`ifdef CODEWORD_ERRCNT_EN
  , parameter int ERR_W = 4
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_in,
  input  logic bit_valid,
  output logic c1,
  output logic c2,
  output logic c3,
  output logic c4,
  output logic c6,
  output logic word_ok,
  output logic parity_err,
  output logic frame_abort,
  output logic busy
`ifdef CODEWORD_ERRCNT_EN
  , output logic [ERR_W-1:0] err_count
`endif
);

  localparam int            TW         = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_VAL     = TW'(TIMEOUT_CYC);
  localparam logic          PAR_TARGET = (PARITY_ODD != 0);

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d, timer_inc;
  logic            res_vld_q, res_vld_d, res_ok_q, res_ok_d;
  logic [PL_W-1:0] res_pl_q, res_pl_d, payload_q, payload_d;
  logic            word_ok_q, word_ok_d, parity_err_q, parity_err_d;
  logic            abort_q, abort_d;
  logic            sh_clr, sh_load, sh_full;
  logic [CW_W-1:0] sh_data;

  cw_shift6 u_shift (
    .clk    (clk),
    .rst    (rst),
    .clr    (sh_clr),
    .load   (sh_load),
    .bit_in (bit_in),
    .data   (sh_data),
    .full   (sh_full)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    timer_inc = timer_q + 1'b1;
    sh_clr    = 1'b0;
    sh_load   = 1'b0;
    abort_d   = 1'b0;
    res_vld_d = 1'b0;
    res_ok_d  = res_ok_q;
    res_pl_d  = res_pl_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          sh_clr  = 1'b1;
          timer_d = '0;
        end
      end
      SHIFT: begin
        if (start) begin
          sh_clr  = 1'b1;
          timer_d = '0;
        end else if (bit_valid) begin
          sh_load = 1'b1;
          timer_d = '0;
          if (sh_full) state_d = CHECK;
        end else if (timer_inc == TO_VAL) begin
          state_d = IDLE;
          timer_d = '0;
          abort_d = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end
      CHECK: begin
        res_vld_d = 1'b1;
        res_ok_d  = ((^sh_data) == PAR_TARGET);
        res_pl_d  = extract_payload(sh_data);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // CHECK result is staged once so payload and pulses land two edges after the 6th bit.
    word_ok_d    = res_vld_q & res_ok_q;
    parity_err_d = res_vld_q & ~res_ok_q;
    payload_d    = word_ok_d ? res_pl_q : payload_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      res_vld_q    <= 1'b0;
      res_ok_q     <= 1'b0;
      res_pl_q     <= '0;
      payload_q    <= '0;
      word_ok_q    <= 1'b0;
      parity_err_q <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      res_vld_q    <= res_vld_d;
      res_ok_q     <= res_ok_d;
      res_pl_q     <= res_pl_d;
      payload_q    <= payload_d;
      word_ok_q    <= word_ok_d;
      parity_err_q <= parity_err_d;
      abort_q      <= abort_d;
    end
  end

`ifdef CODEWORD_ERRCNT_EN
  logic [ERR_W-1:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (parity_err_d && (err_q != '1)) err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign err_count = err_q;
`endif

  assign {c6, c4, c3, c2, c1} = payload_q;
  assign word_ok     = word_ok_q;
  assign parity_err  = parity_err_q;
  assign frame_abort = abort_q;
  assign busy        = (state_q != IDLE);

endmodule
